alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer_if.sv | 56 +++++
 rtl/alu_cmd_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of command, ALU-side and result signals for alu_cmd_sequencer.
// slave: the sequencer's view; master: the environment's view (source of
// commands, ALU model, result consumer).
interface alu_cmd_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  // Command side
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [WIDTH-1:0] CMD_A;
  logic [WIDTH-1:0] CMD_B;
  logic [3:0]       CMD_FUN;

  // ALU side
  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [3:0]       ALU_FUN;
  logic [WIDTH-1:0] ALU_ARITH_OUT;
  logic [WIDTH-1:0] ALU_LOGIC_OUT;
  logic [WIDTH-1:0] ALU_CMP_OUT;
  logic [WIDTH-1:0] ALU_SHIFT_OUT;
  logic             ALU_CARRY;
  logic [3:0]       ALU_FLAGS;

  // Result side
  logic             RES_VALID;
  logic             RES_READY;
  logic [WIDTH-1:0] RES_DATA;
  logic             RES_CARRY;
  logic [1:0]       RES_UNIT;
  logic             RES_ERR;
  logic             ERR_STICKY;
  logic             BUSY;

  modport slave (
    input  CMD_VALID, CMD_A, CMD_B, CMD_FUN,
    input  ALU_ARITH_OUT, ALU_LOGIC_OUT, ALU_CMP_OUT, ALU_SHIFT_OUT,
    input  ALU_CARRY, ALU_FLAGS,
    input  RES_READY,
    output CMD_READY,
    output ALU_A, ALU_B, ALU_FUN,
    output RES_VALID, RES_DATA, RES_CARRY, RES_UNIT, RES_ERR,
    output ERR_STICKY, BUSY
  );

  modport master (
    output CMD_VALID, CMD_A, CMD_B, CMD_FUN,
    output ALU_ARITH_OUT, ALU_LOGIC_OUT, ALU_CMP_OUT, ALU_SHIFT_OUT,
    output ALU_CARRY, ALU_FLAGS,
    output RES_READY,
    input  CMD_READY,
    input  ALU_A, ALU_B, ALU_FUN,
    input  RES_VALID, RES_DATA, RES_CARRY, RES_UNIT, RES_ERR,
    input  ERR_STICKY, BUSY
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a registered multi-unit ALU: queues {A,B,FUN}
// commands in a small FIFO, issues them one at a time to the ALU, captures
// the selected unit's result, checks the unit-active flags and presents the
// result with a valid/ready handshake.
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input logic               CLK,
  input logic               RST,
  alu_cmd_sequencer_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // FIFO storage and control
  logic [WIDTH-1:0] a_mem   [DEPTH];
  logic [WIDTH-1:0] b_mem   [DEPTH];
  logic [3:0]       fun_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             cmd_ready;
  logic             push;
  logic             pop;

  // FSM and registered outputs
  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_fun_q, alu_fun_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_carry_q, res_carry_d;
  logic [1:0]       res_unit_q, res_unit_d;
  logic             res_err_q, res_err_d;
  logic             sticky_q, sticky_d;

  // Full FIFO refuses a push even when the head is popped in the same cycle
  assign cmd_ready = !RST && (count_q < DEPTH_C);
  assign push      = bus.CMD_VALID && cmd_ready;

  // FIFO pointer/count next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write (data needs no reset; pointers/count guard validity)
  always_ff @(posedge CLK) begin
    if (push) begin
      a_mem[wr_ptr_q]   <= bus.CMD_A;
      b_mem[wr_ptr_q]   <= bus.CMD_B;
      fun_mem[wr_ptr_q] <= bus.CMD_FUN;
    end
  end

  // FSM next-state, pop decision, ALU operand load and result capture
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_unit_d  = res_unit_q;
    res_err_d   = res_err_q;
    sticky_d    = sticky_q;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // Unit is taken from the issued function code, which stays put
        // until the next pop.
        res_unit_d = alu_fun_q[3:2];
        case (alu_fun_q[3:2])
          2'b00:   res_data_d = bus.ALU_ARITH_OUT;
          2'b01:   res_data_d = bus.ALU_LOGIC_OUT;
          2'b10:   res_data_d = bus.ALU_CMP_OUT;
          default: res_data_d = bus.ALU_SHIFT_OUT;
        endcase
        res_carry_d = (alu_fun_q[3:2] == 2'b00) ? bus.ALU_CARRY : 1'b0;
        res_err_d   = (bus.ALU_FLAGS != (4'b1000 >> alu_fun_q[3:2]));
        sticky_d    = sticky_q | res_err_d;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_valid_q && bus.RES_READY) begin
          res_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      alu_a_d   = a_mem[rd_ptr_q];
      alu_b_d   = b_mem[rd_ptr_q];
      alu_fun_d = fun_mem[rd_ptr_q];
    end
  end

  // State, FIFO control and output registers with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_unit_q  <= '0;
      res_err_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_unit_q  <= res_unit_d;
      res_err_q   <= res_err_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.CMD_READY  = cmd_ready;
  assign bus.ALU_A      = alu_a_q;
  assign bus.ALU_B      = alu_b_q;
  assign bus.ALU_FUN    = alu_fun_q;
  assign bus.RES_VALID  = res_valid_q;
  assign bus.RES_DATA   = res_data_q;
  assign bus.RES_CARRY  = res_carry_q;
  assign bus.RES_UNIT   = res_unit_q;
  assign bus.RES_ERR    = res_err_q;
  assign bus.ERR_STICKY = sticky_q;
  assign bus.BUSY       = (count_q != '0) || (state_q != IDLE);

endmodule
